mem_access_requester: RTL
=========================

MEM_ACCESS_REQUESTER -- requirements
Module: mem_access_requester

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the width of one memory data word.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: transaction request, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 1 bit: 0 = read, 1 = write, latched with start.
REQ-006 The block SHALL have port diff, input, 1 bit: 1 = per-core distinct access, 0 = shared access, latched with start.
REQ-007 The block SHALL have port noc, input, 3 bits: number of active cores, 1..4, latched with start as noc_l.
REQ-008 The block SHALL have port data_out_sel, input, 4 bits: one-hot or all-ones per-core read strobe from the memory control unit.
REQ-009 The block SHALL have port mem_rd_data, input, DATA_W bits: memory read data, valid while data_out_sel is non-zero.
REQ-010 The block SHALL have port mem_read, output, 2 bits: read command; bit0 = request, bit1 = diff.
REQ-011 The block SHALL have port mem_write, output, 2 bits: write command; bit0 = request, bit1 = diff.
REQ-012 The block SHALL have port rd_data, output, 4*DATA_W bits: captured word for core k in bits [k*DATA_W +: DATA_W].
REQ-013 The block SHALL have port rd_mask, output, 4 bits: bit k set when core k's word has been captured in the current transaction.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 The block SHALL have port err, output, 1 bit: error status, valid while done is high and held until the next accepted start.

Function
REQ-017 The FSM SHALL have five states: IDLE, ISSUE, WAIT_RD, WAIT_WR, DONE; all outputs SHALL be registered.
REQ-018 IDLE, start=1 with noc in 1..4: latch op, diff, noc_l; clear rd_mask, err and wait counter cnt (3 bits); go to ISSUE.
REQ-019 IDLE, start=1 with noc = 0 or noc > 4: go directly to DONE with err=1; mem_read and mem_write SHALL stay 00.
REQ-020 ISSUE SHALL last exactly one cycle, driving {diff,1} on mem_read (read) or mem_write (write) with the other at 00; next state is WAIT_RD or WAIT_WR.
REQ-021 Outside ISSUE, mem_read and mem_write SHALL be 00.
REQ-022 WAIT_RD, diff=1: on each edge where data_out_sel[k]=1 and k < noc_l, load rd_data[k] with mem_rd_data and set rd_mask[k]; ignore strobe bits for k >= noc_l.
REQ-023 WAIT_RD, diff=1: the edge that captures core noc_l-1 SHALL transition to DONE.
REQ-024 WAIT_RD, diff=0: on data_out_sel = 4'b1111, load mem_rd_data into rd_data[k] for every k < noc_l, set those rd_mask bits, and go to DONE.
REQ-025 WAIT_RD: cnt SHALL increment every cycle; if completion has not occurred when cnt = 7, go to DONE with err=1; captured words and mask bits SHALL be retained.
REQ-026 WAIT_WR SHALL last noc_l cycles when diff=1 and 1 cycle when diff=0, then go to DONE with err=0.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-028 A start arriving in any state other than IDLE, including DONE, SHALL be ignored and not queued.
REQ-029 data_out_sel SHALL be ignored in IDLE, ISSUE, WAIT_WR and DONE.
REQ-030 rd_data SHALL hold its value between transactions; only rd_mask SHALL be cleared at start.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE and set mem_read=00, mem_write=00, busy=0, done=0, err=0, rd_mask=0, rd_data=0, cnt=0, regardless of clk.
REQ-032 Reset asserted mid-transaction SHALL abort that transaction with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification
REQ-033 Diff read, noc=3: strobes 0001/0010/0100 with data 0x11/0x22/0x33 on consecutive cycles -> rd_data0..2 = 11/22/33, rd_mask=0111, mem_read=11 for one cycle, done one cycle after the last strobe, err=0.
REQ-034 Shared read, noc=4: mem_read=01 pulse, then data_out_sel=1111 with data 0x5A -> all four words = 5A, rd_mask=1111, err=0.
REQ-035 Diff write, noc=4: mem_write=11 for one cycle, 4 WAIT_WR cycles, then done=1, err=0; mem_read stays 00 throughout.
REQ-036 Read with no strobes: done on the cycle after cnt reaches 7 (eight WAIT_RD cycles), err=1, rd_mask=0000.
REQ-037 start with noc=0 -> done=1 and err=1 one cycle later, no command pulse; start during busy -> ignored.
REQ-038 rst_n pulsed low during WAIT_RD -> all outputs 0 asynchronously, no done pulse, next start completes normally.

Source files
------------

// File: rtl/mem_access_requester.sv
// Memory access requester: issues one read or write command per accepted start,
// collects per-core read words with a bounded wait, and pulses done on completion.
module mem_access_requester #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op,
    input  logic                  diff,
    input  logic [2:0]            noc,
    input  logic [3:0]            data_out_sel,
    input  logic [DATA_W-1:0]     mem_rd_data,
    output logic [1:0]            mem_read,
    output logic [1:0]            mem_write,
    output logic [4*DATA_W-1:0]   rd_data,
    output logic [3:0]            rd_mask,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        WAIT_WR,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic        op_l, diff_l;
    logic [2:0]  noc_l;
    logic [2:0]  cnt;
    logic        noc_ok, accept, rd_done, timeout, wr_last;
    logic [3:0]  core_en, cap;
    logic [1:0]  last_core;

    assign noc_ok    = (noc != 3'd0) && (noc <= 3'd4);
    assign accept    = (state == IDLE) && start;
    assign core_en   = 4'b1111 >> (3'd4 - noc_l);
    assign last_core = 2'(noc_l - 3'd1);

    // Strobe bits for cores beyond noc_l never reach the capture vector.
    always_comb begin
        cap = 4'b0000;
        if (state == WAIT_RD) begin
            if (diff_l)
                cap = data_out_sel & core_en;
            else if (data_out_sel == 4'b1111)
                cap = core_en;
        end
    end

    assign rd_done = diff_l ? cap[last_core] : (cap != 4'b0000);
    assign timeout = (cnt == 3'd7) && !rd_done;
    assign wr_last = (cnt == (diff_l ? (noc_l - 3'd1) : 3'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = noc_ok ? ISSUE : DONE;
            ISSUE:   state_nxt = op_l ? WAIT_WR : WAIT_RD;
            WAIT_RD: if (rd_done || timeout) state_nxt = DONE;
            WAIT_WR: if (wr_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every register here uses non-blocking assignment so all of them
    // see the same pre-edge values of state, cnt and cap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read  <= 2'b00;
            mem_write <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rd_mask   <= 4'b0000;
            // NOTE: the capture words are explicitly reset; software may read
            // rd_data before any transaction and must see zeros.
            rd_data   <= '0;
            cnt       <= 3'd0;
            op_l      <= 1'b0;
            diff_l    <= 1'b0;
            noc_l     <= 3'd0;
        end else begin
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
            mem_read  <= 2'b00;
            mem_write <= 2'b00;
            // ISSUE is only entered from IDLE, so the live op/diff inputs are
            // exactly the values being latched on this edge.
            if (state_nxt == ISSUE) begin
                if (op)
                    mem_write <= {diff, 1'b1};
                else
                    mem_read  <= {diff, 1'b1};
            end

            if (accept) begin
                if (noc_ok) begin
                    op_l    <= op;
                    diff_l  <= diff;
                    noc_l   <= noc;
                    rd_mask <= 4'b0000;
                    err     <= 1'b0;
                    cnt     <= 3'd0;
                end else begin
                    err     <= 1'b1;
                end
            end

            if (state == WAIT_RD) begin
                cnt     <= cnt + 3'd1;
                rd_mask <= rd_mask | cap;
                if (timeout)
                    err <= 1'b1;
            end

            if (state == WAIT_WR)
                cnt <= cnt + 3'd1;

            for (int k = 0; k < 4; k++) begin
                if (cap[k])
                    rd_data[k*DATA_W +: DATA_W] <= mem_rd_data;
            end
        end
    end

endmodule
